// File: rtl/i2c_eeprom_sequencer_if.sv
// Host request/response and i2cUnit command signals of the EEPROM sequencer.
// Latency: none (wiring only).
// Backpressure: reqReady throttles the host; i2cBusy throttles the sequencer.
interface i2c_eeprom_sequencer_if;
  // host side
  logic       reqValid;
  logic       reqWrite;
  logic [7:0] reqAddr;
  logic [7:0] reqData;
  logic       reqReady;
  logic       respValid;
  logic [7:0] respData;
  logic       respError;
  // i2cUnit side
  logic [1:0] i2cCommand;
  logic [7:0] i2cWriteData;
  logic       i2cTransactionValid;
  logic       i2cBusy;
  logic [7:0] i2cReadData;

  // the sequencer itself
  modport slave (
    input  reqValid, reqWrite, reqAddr, reqData, i2cBusy, i2cReadData,
    output reqReady, respValid, respData, respError,
           i2cCommand, i2cWriteData, i2cTransactionValid
  );

  // whatever drives the sequencer (host plus i2cUnit)
  modport master (
    output reqValid, reqWrite, reqAddr, reqData, i2cBusy, i2cReadData,
    input  reqReady, respValid, respData, respError,
           i2cCommand, i2cWriteData, i2cTransactionValid
  );
endinterface

// File: rtl/i2c_eeprom_sequencer.sv
// Sequences i2cUnit commands for single-byte EEPROM write / random read with ack polling.
// Latency: one command per ISSUE/WAIT pair plus DONE; response pulse one cycle after STOP completes.
// Backpressure: reqReady only in IDLE; each command waits for i2cBusy to rise and then fall.
module i2c_eeprom_sequencer #(
  parameter logic [6:0]  DEVICE_ADDR = 7'b1010000,
  parameter int unsigned MAX_POLL    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  i2c_eeprom_sequencer_if.slave        bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_CTRL_W  = 4'd2,
    S_ADDR    = 4'd3,
    S_DATA    = 4'd4,
    S_RESTART = 4'd5,
    S_CTRL_R  = 4'd6,
    S_RECV    = 4'd7,
    S_STOP    = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_TX    = 2'b10;
  localparam logic [1:0] CMD_RX    = 2'b11;
  localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLL);

  state_t     state_q, state_d;
  logic       wait_q, wait_d;        // 0: ISSUE phase, 1: WAIT phase
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] poll_q, poll_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       resp_vld_q, resp_vld_d;
  logic       resp_err_q, resp_err_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic [1:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic       txn_vld_q, txn_vld_d;

  logic       launch;
  state_t     launch_state;
  logic       slave_ack;

  // Command opcode and byte that each command state puts on the i2cUnit port.
  function automatic logic [9:0] cmd_for(state_t s, logic [7:0] a, logic [7:0] d);
    logic [9:0] r;
    case (s)
      S_START, S_RESTART: r = {CMD_START, 8'h00};
      S_CTRL_W:           r = {CMD_TX, DEVICE_ADDR, 1'b0};
      S_ADDR:             r = {CMD_TX, a};
      S_DATA:             r = {CMD_TX, d};
      S_CTRL_R:           r = {CMD_TX, DEVICE_ADDR, 1'b1};
      S_RECV:             r = {CMD_RX, 8'h01};   // NACK the single read byte
      S_STOP:             r = {CMD_STOP, 8'h00};
      default:            r = {CMD_START, 8'h00};
    endcase
    return r;
  endfunction

  assign slave_ack = ~bus.i2cReadData[0];

  // Next-state logic: ISSUE/WAIT handshake per command, byte sequencing, ack polling.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    poll_d       = poll_q;
    rbyte_d      = rbyte_q;
    err_d        = err_q;
    ready_d      = ready_q;
    resp_vld_d   = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = 8'h00;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    txn_vld_d    = txn_vld_q;
    launch       = 1'b0;
    launch_state = state_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.reqValid && ready_q) begin
          write_d      = bus.reqWrite;
          addr_d       = bus.reqAddr;
          data_d       = bus.reqData;
          poll_d       = 8'h00;
          err_d        = 1'b0;
          rbyte_d      = 8'h00;
          ready_d      = 1'b0;
          launch       = 1'b1;
          launch_state = S_START;
        end
      end

      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        if (!wait_q) begin
          // ISSUE: hold the request until the unit reports it has started
          if (bus.i2cBusy) begin
            txn_vld_d = 1'b0;
            wait_d    = 1'b1;
          end
        end else if (!bus.i2cBusy) begin
          // WAIT finished: decide what comes next; it issues from the next cycle
          launch = 1'b1;
          case (state_q)
            S_START:   launch_state = S_CTRL_W;
            S_CTRL_W: begin
              if (slave_ack) begin
                launch_state = S_ADDR;
              end else if (poll_q == POLL_LIMIT) begin
                launch_state = S_STOP;
                err_d        = 1'b1;
              end else begin
                // device busy with an internal write cycle: repeated start, try again
                poll_d       = poll_q + 8'd1;
                launch_state = S_START;
              end
            end
            S_ADDR: begin
              if (!slave_ack) begin
                launch_state = S_STOP;
                err_d        = 1'b1;
              end else begin
                launch_state = write_q ? S_DATA : S_RESTART;
              end
            end
            S_DATA: begin
              launch_state = S_STOP;
              if (!slave_ack) err_d = 1'b1;
            end
            S_RESTART: launch_state = S_CTRL_R;
            S_CTRL_R: begin
              if (slave_ack) begin
                launch_state = S_RECV;
              end else begin
                launch_state = S_STOP;
                err_d        = 1'b1;
              end
            end
            S_RECV: begin
              rbyte_d      = bus.i2cReadData;
              launch_state = S_STOP;
            end
            S_STOP: begin
              launch      = 1'b0;
              state_d     = S_DONE;
              resp_vld_d  = 1'b1;
              resp_err_d  = err_q;
              resp_data_d = (!write_q && !err_q) ? rbyte_q : 8'h00;
            end
            default: begin
              launch  = 1'b0;
              state_d = S_IDLE;
            end
          endcase
        end
      end
    endcase

    if (launch) begin
      state_d          = launch_state;
      wait_d           = 1'b0;
      txn_vld_d        = 1'b1;
      {cmd_d, wdata_d} = cmd_for(launch_state, addr_d, data_d);
    end
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      poll_q      <= 8'h00;
      rbyte_q     <= 8'h00;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      resp_vld_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= 8'h00;
      cmd_q       <= CMD_START;
      wdata_q     <= 8'h00;
      txn_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      poll_q      <= poll_d;
      rbyte_q     <= rbyte_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      resp_vld_q  <= resp_vld_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      txn_vld_q   <= txn_vld_d;
    end
  end

  assign bus.reqReady            = ready_q;
  assign bus.respValid           = resp_vld_q;
  assign bus.respError           = resp_err_q;
  assign bus.respData            = resp_data_q;
  assign bus.i2cCommand          = cmd_q;
  assign bus.i2cWriteData        = wdata_q;
  assign bus.i2cTransactionValid = txn_vld_q;

endmodule

// File: tb/tb_i2c_eeprom_sequencer.sv
// Bench: two sequencer instances (default MAX_POLL and MAX_POLL=2) sharing one EEPROM/i2cUnit model.
// The model logs every command; expected sequences come from a byte-level reference of the protocol.
// Table vectors, randomized transactions and a mid-transaction reset sequence.
module tb_i2c_eeprom_sequencer;

  localparam logic [7:0] CW = 8'hA0;
  localparam logic [7:0] CR = 8'hA1;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] wd;
  } cmd_t;

  typedef struct {
    bit         s;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    int         nacks;
    bit         na;
    bit         nd;
    bit         ncr;
    bit         pre_en;
    logic [7:0] pre;
    bit         exp_err;
    logic [7:0] exp_data;
    int         exp_ncmd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       req_valid, req_write;
  logic [7:0] req_addr, req_data;
  logic       dev_busy;
  logic [7:0] dev_rdata;

  always #5 clk = ~clk;

  i2c_eeprom_sequencer_if ifa();
  i2c_eeprom_sequencer_if ifb();

  assign ifa.reqValid    = req_valid & ~sel;
  assign ifb.reqValid    = req_valid & sel;
  assign ifa.reqWrite    = req_write;
  assign ifb.reqWrite    = req_write;
  assign ifa.reqAddr     = req_addr;
  assign ifb.reqAddr     = req_addr;
  assign ifa.reqData     = req_data;
  assign ifb.reqData     = req_data;
  assign ifa.i2cBusy     = dev_busy & ~sel;
  assign ifb.i2cBusy     = dev_busy & sel;
  assign ifa.i2cReadData = dev_rdata;
  assign ifb.i2cReadData = dev_rdata;

  i2c_eeprom_sequencer dut_a (.clk(clk), .reset(reset), .bus(ifa));
  i2c_eeprom_sequencer #(.MAX_POLL(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  wire       m_ready    = sel ? ifb.reqReady : ifa.reqReady;
  wire       m_resp_vld = sel ? ifb.respValid : ifa.respValid;
  wire       m_resp_err = sel ? ifb.respError : ifa.respError;
  wire [7:0] m_resp_dat = sel ? ifb.respData : ifa.respData;
  wire       m_tvalid   = sel ? ifb.i2cTransactionValid : ifa.i2cTransactionValid;
  wire [1:0] m_cmd      = sel ? ifb.i2cCommand : ifa.i2cCommand;
  wire [7:0] m_wdata    = sel ? ifb.i2cWriteData : ifa.i2cWriteData;

  int checks = 0;
  int failures = 0;

  // device model state
  cmd_t       log_q[$];
  logic [7:0] dev_mem[256];
  int         dev_idx;
  logic [7:0] dev_ptr;
  int         ctrl_nacks_left;
  bit         nack_addr_cfg, nack_data_cfg, nack_ctrlr_cfg;
  bit         hold_long = 1'b0;
  int         prot_errs = 0;

  // reference model state
  cmd_t       exp_q[$];
  logic [7:0] ref_mem[256];
  bit         exp_err;
  logic [7:0] exp_rdat;

  // last transaction results
  bit         got_resp;
  logic       r_err;
  logic [7:0] r_data;
  int         r_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave behaviour for one command; returns what the unit reports in i2cReadData.
  function automatic logic [7:0] respond(cmd_t c);
    logic nack;
    nack = 1'b0;
    case (c.cmd)
      2'b00: begin dev_idx = 0; return 8'h00; end
      2'b01: return 8'h00;
      2'b11: return dev_mem[dev_ptr];
      default: begin
        if (dev_idx == 0) begin
          if (c.wd == CW) begin
            if (ctrl_nacks_left > 0) begin nack = 1'b1; ctrl_nacks_left--; end
          end else if (c.wd == CR) begin
            nack = nack_ctrlr_cfg;
          end else begin
            nack = 1'b1;
          end
        end else if (dev_idx == 1) begin
          if (nack_addr_cfg) nack = 1'b1; else dev_ptr = c.wd;
        end else if (dev_idx == 2) begin
          if (nack_data_cfg) nack = 1'b1; else dev_mem[dev_ptr] = c.wd;
        end else begin
          nack = 1'b1;
        end
        dev_idx++;
        return {7'b0, nack};
      end
    endcase
  endfunction

  task automatic stable_chk(input cmd_t c, input logic exp_vld);
    if (!reset && (m_cmd !== c.cmd || m_wdata !== c.wd || m_tvalid !== exp_vld)) prot_errs++;
  endtask

  // i2cUnit model: accept a command, random start delay, random busy length
  initial begin : device
    cmd_t       c;
    logic [7:0] resp;
    int         d0, d1;
    dev_busy  = 1'b0;
    dev_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && m_tvalid && !dev_busy) begin
        c = '{cmd: m_cmd, wd: m_wdata};
        log_q.push_back(c);
        resp = respond(c);
        d0 = $urandom_range(0, 2);
        repeat (d0) begin @(negedge clk); stable_chk(c, 1'b1); end
        dev_busy = 1'b1;
        d1 = hold_long ? 6 : $urandom_range(1, 3);
        repeat (d1) begin @(negedge clk); stable_chk(c, 1'b0); end
        dev_rdata = resp;
        dev_busy  = 1'b0;
      end
    end
  end

  // Byte-level reference: the command list a compliant sequencer must produce.
  function automatic void build_expected(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                         input int nacks, input bit na, input bit nd, input bit ncr,
                                         input int maxp);
    int nacked;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_rdat = 8'h00;
    nacked = (nacks > maxp + 1) ? maxp + 1 : nacks;
    for (int i = 0; i < nacked; i++) begin
      exp_q.push_back('{2'b00, 8'h00});
      exp_q.push_back('{2'b10, CW});
    end
    if (nacks >= maxp + 1) begin
      exp_err = 1'b1;
      exp_q.push_back('{2'b01, 8'h00});
      return;
    end
    exp_q.push_back('{2'b00, 8'h00});
    exp_q.push_back('{2'b10, CW});
    exp_q.push_back('{2'b10, a});
    if (na) begin
      exp_err = 1'b1;
      exp_q.push_back('{2'b01, 8'h00});
      return;
    end
    if (wr) begin
      exp_q.push_back('{2'b10, d});
      if (nd) exp_err = 1'b1; else ref_mem[a] = d;
      exp_q.push_back('{2'b01, 8'h00});
      return;
    end
    exp_q.push_back('{2'b00, 8'h00});
    exp_q.push_back('{2'b10, CR});
    if (ncr) begin
      exp_err = 1'b1;
      exp_q.push_back('{2'b01, 8'h00});
      return;
    end
    exp_q.push_back('{2'b11, 8'h01});
    exp_rdat = ref_mem[a];
    exp_q.push_back('{2'b01, 8'h00});
  endfunction

  function automatic bit seq_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_req(input bit s, input bit wr, input logic [7:0] a, input logic [7:0] d,
                           input bit scramble);
    int t;
    @(negedge clk);
    sel = s;
    log_q.delete();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    t = 0;
    while (!m_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);   // accepted on the edge just passed
    req_valid = 1'b0;
    if (scramble) begin
      req_write = ~wr;
      req_addr  = 8'($urandom);
      req_data  = 8'($urandom);
    end
  endtask

  task automatic do_txn(input string nm, input bit s, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int nacks, input bit na, input bit nd,
                        input bit ncr, input bit scramble);
    int t;
    bit seq_ok;
    ctrl_nacks_left = nacks;
    nack_addr_cfg   = na;
    nack_data_cfg   = nd;
    nack_ctrlr_cfg  = ncr;
    build_expected(wr, a, d, nacks, na, nd, ncr, s ? 2 : 255);
    start_req(s, wr, a, d, scramble);
    r_count  = 0;
    got_resp = 1'b0;
    t = 0;
    while (t < 20000) begin
      if (ifa.respValid || ifb.respValid) begin
        r_count++;
        got_resp = 1'b1;
        r_err  = m_resp_err;
        r_data = m_resp_dat;
        check({nm, "_rdy_done"}, 64'(m_ready), 64'd0);
        break;
      end
      @(negedge clk);
      t++;
    end
    check({nm, "_resp"}, 64'(got_resp), 64'd1);
    repeat (3) begin
      @(negedge clk);
      if (ifa.respValid || ifb.respValid) r_count++;
    end
    check({nm, "_npulse"}, 64'(r_count), 64'd1);
    check({nm, "_rdy_idle"}, 64'(m_ready), 64'd1);
    check({nm, "_err"}, 64'(r_err), 64'(exp_err));
    check({nm, "_data"}, 64'(r_data), 64'(exp_rdat));
    seq_ok = seq_match();
    if (!seq_ok) $display("note %s: %0d commands seen, %0d expected", nm, log_q.size(), exp_q.size());
    check({nm, "_cmdseq"}, 64'(seq_ok), 64'd1);
  endtask

  vec_t tbl[11];

  initial begin : main
    int t;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    tbl[0]  = '{0, 1, 8'h03, 8'h5A, 0,   0, 0, 0, 0, 8'h00, 0, 8'h00, 5};
    tbl[1]  = '{0, 0, 8'h07, 8'h00, 0,   0, 0, 0, 1, 8'hC3, 0, 8'hC3, 7};
    tbl[2]  = '{0, 1, 8'h10, 8'h33, 3,   0, 0, 0, 0, 8'h00, 0, 8'h00, 11};
    tbl[3]  = '{1, 1, 8'h11, 8'h44, 255, 0, 0, 0, 0, 8'h00, 1, 8'h00, 7};
    tbl[4]  = '{0, 1, 8'h12, 8'h55, 0,   1, 0, 0, 0, 8'h00, 1, 8'h00, 4};
    tbl[5]  = '{0, 1, 8'h13, 8'h66, 0,   0, 1, 0, 0, 8'h00, 1, 8'h00, 5};
    tbl[6]  = '{0, 0, 8'h14, 8'h00, 0,   0, 0, 1, 1, 8'h77, 1, 8'h00, 6};
    tbl[7]  = '{0, 0, 8'h03, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0, 8'h5A, 7};
    tbl[8]  = '{1, 1, 8'h20, 8'h99, 2,   0, 0, 0, 0, 8'h00, 0, 8'h00, 9};
    tbl[9]  = '{0, 1, 8'h21, 8'hAA, 256, 0, 0, 0, 0, 8'h00, 1, 8'h00, 513};
    tbl[10] = '{1, 0, 8'h07, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0, 8'hC3, 7};

    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_data = 8'h00;
    ctrl_nacks_left = 0; nack_addr_cfg = 0; nack_data_cfg = 0; nack_ctrlr_cfg = 0;
    dev_idx = 0; dev_ptr = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ifa.reqReady), 64'd1);
    check("rst_respv", 64'(ifa.respValid), 64'd0);
    check("rst_respd", 64'(ifa.respData), 64'd0);
    check("rst_respe", 64'(ifa.respError), 64'd0);
    check("rst_tvalid", 64'(ifa.i2cTransactionValid), 64'd0);
    check("rst_cmd", 64'(ifa.i2cCommand), 64'd0);
    check("rst_wdata", 64'(ifa.i2cWriteData), 64'd0);
    check("rst_ready_b", 64'(ifb.reqReady), 64'd1);
    reset = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].pre_en) begin
        dev_mem[tbl[i].a] = tbl[i].pre;
        ref_mem[tbl[i].a] = tbl[i].pre;
      end
      do_txn($sformatf("v%0d", i), tbl[i].s, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].nacks,
             tbl[i].na, tbl[i].nd, tbl[i].ncr, 1'b0);
      check($sformatf("v%0d_terr", i), 64'(r_err), 64'(tbl[i].exp_err));
      check($sformatf("v%0d_tdata", i), 64'(r_data), 64'(tbl[i].exp_data));
      check($sformatf("v%0d_ncmd", i), 64'(log_q.size()), 64'(tbl[i].exp_ncmd));
    end

    // randomized transactions with inputs scrambled after acceptance
    for (int i = 0; i < 40; i++) begin
      int r, nk;
      r  = $urandom_range(0, 9);
      nk = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 3) : 300;
      do_txn($sformatf("r%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom), nk, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b1);
    end

    // reset while the data byte is in its WAIT phase
    hold_long = 1'b1;
    ctrl_nacks_left = 0; nack_addr_cfg = 0; nack_data_cfg = 0; nack_ctrlr_cfg = 0;
    start_req(1'b0, 1'b1, 8'h40, 8'h81, 1'b0);
    t = 0;
    while (!(log_q.size() == 4 && dev_busy) && t < 200) begin @(negedge clk); t++; end
    check("rst_mid_reach", 64'(t < 200), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_ready", 64'(ifa.reqReady), 64'd1);
    check("mid_respv", 64'(ifa.respValid), 64'd0);
    check("mid_respd", 64'(ifa.respData), 64'd0);
    check("mid_respe", 64'(ifa.respError), 64'd0);
    check("mid_tvalid", 64'(ifa.i2cTransactionValid), 64'd0);
    check("mid_cmd", 64'(ifa.i2cCommand), 64'd0);
    check("mid_wdata", 64'(ifa.i2cWriteData), 64'd0);
    r_count = 0;
    t = 0;
    while (dev_busy && t < 50) begin
      @(negedge clk);
      if (ifa.respValid) r_count++;
      t++;
    end
    hold_long = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ifa.respValid) r_count++;
    end
    check("mid_no_resp", 64'(r_count), 64'd0);
    check("mid_no_stop", 64'(log_q.size()), 64'd4);
    check("mid_last_data", 64'(log_q[log_q.size() - 1]), 64'({2'b10, 8'h81}));
    do_txn("post_rst", 1'b0, 1'b1, 8'h41, 8'h82, 0, 0, 0, 0, 1'b0);
    do_txn("post_rd", 1'b0, 1'b0, 8'h41, 8'h00, 0, 0, 0, 0, 1'b0);

    check("protocol", 64'(prot_errs), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
